eth_tx_sequencer: RTL and testbench
===================================

# eth_tx_sequencer

Frame sequencer between the header/payload generators and `rgmii_tx`. On each send request, once the PHY is configured, it emits preamble/SFD, then pulls the Ethernet header, IP header and UDP segment from their generators back-to-back. It pads to minimum length, appends the FCS and enforces the inter-frame gap. It owns the single byte-wide TX path, so generator outputs never reach `rgmii_tx` unsequenced.

## Interface
- `IFG_BYTES`, 12: idle cycles after each frame, tx_valid low.
- `MIN_FRAME`, 60: minimum bytes from first header byte up to, but excluding, the FCS.
- `MAX_FRAME`, 1514: oversize limit, same span.
- `clk`  in  1  TX byte clock, 125 MHz.
- `rst`  in  1  asynchronous, active-high reset.
- `phy_ready`  in  1  MDIO initialisation done; send ignored while low.
- `send`  in  1  frame request, level-sampled.
- `eth_start`, `ip_start`, `udp_start`  out  1 each  one-cycle segment start pulses.
- `eth_data`/`ip_data`/`udp_data`  in  8  segment bytes.
- `eth_valid`/`ip_valid`/`udp_valid`  in  1  byte present.
- `eth_last`/`ip_last`/`udp_last`  in  1  final byte of segment.
- `tx_data`  out  8  byte to rgmii_tx.
- `tx_valid`  out  1  frame byte valid.
- `tx_err`  out  1  frame aborted, asserted with the last tx_valid byte.
- `busy`  out  1  not in IDLE.
- `frame_done`  out  1  one-cycle pulse after the last FCS byte.

## Operation
- States: IDLE → PREAMBLE (7 × 0x55) → SFD (0xD5) → ETH → IP → UDP → PAD (0x00) → FCS (4 bytes) → IFG (IFG_BYTES) → IDLE. Any state from ETH to PAD can go to ABORT, then IFG.
- IDLE: leave when `send & phy_ready`. `send` with `phy_ready` low is dropped.
- `send` while busy sets a 1-deep pending flag. Pending is serviced from IFG exit without returning through IDLE. Further sends while pending is set are dropped.
- Segment handshake:
  - The `X_start` pulse is high in cycle n.
  - The source must hold `X_valid`=1 from cycle n+1 with one new byte every cycle until `X_last`.
  - The sequencer consumes one byte per cycle.
  - When `X_last` is sampled, the next segment's start pulse goes high in the same cycle, so there is no gap between segments.
- Underrun: `X_valid`=0 in any expected cycle causes ABORT. The sequencer then drives `tx_err`=1 and `tx_valid`=1 for one cycle, and emits no FCS.
- Byte counter: 11 bits, counts bytes from the first ETH byte. Counter reaching MAX_FRAME before `udp_last` is sampled causes ABORT.
- PAD: entered after `udp_last` only if count < MIN_FRAME; emits zeros until count = MIN_FRAME.
- CRC:
  - IEEE 802.3 CRC-32, reflected, poly 0x04C11DB7.
  - Initialised to 0xFFFFFFFF on the SFD cycle.
  - Updated on every ETH/IP/UDP/PAD byte.
  - FCS is the complemented CRC, least significant byte first.
- `frame_done` pulses on the cycle after the 4th FCS byte. It does not pulse for aborted frames.

## Timing
- Reset values: tx_data 0x00; tx_valid, tx_err, busy, frame_done and all start pulses 0. State is IDLE, pending cleared, CRC 0xFFFFFFFF, counter 0.
- Reset asserted mid-frame: outputs go to reset values immediately (asynchronous); no FCS and no frame_done.
- All outputs are registered.
- Sequence for `send` sampled at edge 0:
  - 0x55 after edges 1–7.
  - 0xD5 after edge 8; eth_start is high in that same cycle.
  - First eth byte sampled at edge 9 and on tx_data after edge 9.
- tx_valid is continuous from the first preamble byte to the last FCS byte.
- tx_valid stays low for exactly IFG_BYTES cycles before the next preamble.
- Back-to-back pending frames: preamble restarts on the edge after the last IFG cycle.
- `busy` is high from edge 1 through the final IFG cycle.

## Structure
- Package `eth_tx_pkg`:
  - State enum.
  - Constants PREAMBLE_BYTE 8'h55, SFD_BYTE 8'hD5, CRC_POLY, CRC_INIT, CRC_RESIDUE 32'hC704DD7B.
  - Defaults MIN_FRAME and MAX_FRAME.
- Sub-module `crc32_d8`: combinational 8-bit-per-step CRC next-state function. The sequencer holds the CRC register.

## Test plan
- Minimum frame: eth 14, ip 20, udp 8 bytes → 18 zero pad bytes; 72 consecutive tx_valid cycles (8 + 60 + 4); CRC over bytes 9–72 gives residue 0xC704DD7B; frame_done pulses once; then 12 idle cycles.
- Large frame: udp 1480 bytes → no PAD; tx_valid lasts 8 + 1514 + 4 cycles; FCS matches software CRC-32.
- Underrun: udp_valid drops at udp byte 3 → tx_err=1 for one cycle, no FCS, no frame_done, 12 IFG cycles, then IDLE.
- send while phy_ready=0 → no output. send pulsed during FCS → second preamble starts exactly 12 cycles after the first frame's last FCS byte.
- Oversize: udp never asserts udp_last → ABORT when the byte counter reaches 1514, tx_err=1.
- rst asserted during ETH → all outputs 0 immediately. After release with send held high, the next frame is complete with a correct FCS.

Source files
------------

// File: rtl/eth_tx_pkg.sv
// Shared types and constants for the Ethernet TX frame sequencer.
package eth_tx_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_SFD,
    ST_ETH,
    ST_IP,
    ST_UDP,
    ST_PAD,
    ST_FCS,
    ST_IFG,
    ST_ABORT
  } tx_state_t;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hC704DD7B;

  localparam int unsigned IFG_DEF       = 12;
  localparam int unsigned MIN_FRAME_DEF = 60;
  localparam int unsigned MAX_FRAME_DEF = 1514;
  localparam int unsigned CNT_W         = 11;

  // Bit-reverse a 32-bit word (used to derive the LSB-first polynomial).
  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

endpackage

// File: rtl/eth_tx_sequencer_crc32_d8.sv
// Combinational CRC-32 next state for one byte, LSB-first (reflected) form.
module crc32_d8
  import eth_tx_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [7:0]  data,
  output logic [31:0] crc_next
);

  localparam logic [31:0] POLY_R = reflect32(CRC_POLY);

  logic [31:0] c;

  always_comb begin
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ POLY_R;
      else                c = c >> 1;
    end
    crc_next = c;
  end

endmodule

// File: rtl/eth_tx_sequencer.sv
// Sequences preamble, header/payload segments, padding, FCS and IFG onto
// the single byte-wide TX path feeding rgmii_tx.
module eth_tx_sequencer
  import eth_tx_pkg::*;
#(
  parameter int unsigned IFG_BYTES = IFG_DEF,
  parameter int unsigned MIN_FRAME = MIN_FRAME_DEF,
  parameter int unsigned MAX_FRAME = MAX_FRAME_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       phy_ready,
  input  logic       send,
  output logic       eth_start,
  output logic       ip_start,
  output logic       udp_start,
  input  logic [7:0] eth_data,
  input  logic [7:0] ip_data,
  input  logic [7:0] udp_data,
  input  logic       eth_valid,
  input  logic       ip_valid,
  input  logic       udp_valid,
  input  logic       eth_last,
  input  logic       ip_last,
  input  logic       udp_last,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic       tx_err,
  output logic       busy,
  output logic       frame_done
);

  localparam int unsigned IFG_W = $clog2(IFG_BYTES + 1);

  tx_state_t          state;
  logic               pending;
  logic [2:0]         pre_cnt;
  logic [1:0]         fcs_idx;
  logic [IFG_W-1:0]   ifg_cnt;
  logic [CNT_W-1:0]   byte_cnt;
  logic [31:0]        crc;

  logic               seg_valid_c;
  logic               seg_last_c;
  logic [7:0]         seg_data_c;
  logic [7:0]         crc_byte_c;
  logic [31:0]        crc_next_c;
  logic [31:0]        fcs_c;
  logic [CNT_W-1:0]   cnt_inc_c;

  // Select the generator currently owning the byte path.
  always_comb begin
    seg_valid_c = 1'b0;
    seg_last_c  = 1'b0;
    seg_data_c  = 8'h00;
    case (state)
      ST_ETH: begin seg_valid_c = eth_valid; seg_last_c = eth_last; seg_data_c = eth_data; end
      ST_IP:  begin seg_valid_c = ip_valid;  seg_last_c = ip_last;  seg_data_c = ip_data;  end
      ST_UDP: begin seg_valid_c = udp_valid; seg_last_c = udp_last; seg_data_c = udp_data; end
      default: ;
    endcase
  end

  assign crc_byte_c = (state == ST_PAD) ? 8'h00 : seg_data_c;
  assign fcs_c      = ~crc;
  assign cnt_inc_c  = byte_cnt + CNT_W'(1);

  crc32_d8 u_crc (
    .crc      (crc),
    .data     (crc_byte_c),
    .crc_next (crc_next_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      pending    <= 1'b0;
      pre_cnt    <= '0;
      fcs_idx    <= '0;
      ifg_cnt    <= '0;
      byte_cnt   <= '0;
      crc        <= CRC_INIT;
      tx_data    <= 8'h00;
      tx_valid   <= 1'b0;
      tx_err     <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      eth_start  <= 1'b0;
      ip_start   <= 1'b0;
      udp_start  <= 1'b0;
    end else begin
      tx_data    <= 8'h00;
      tx_valid   <= 1'b0;
      tx_err     <= 1'b0;
      frame_done <= 1'b0;
      eth_start  <= 1'b0;
      ip_start   <= 1'b0;
      udp_start  <= 1'b0;
      busy       <= (state != ST_IDLE);

      // A request arriving mid-frame is remembered once.
      if (send && phy_ready && state != ST_IDLE) pending <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (send && phy_ready) begin
            state   <= ST_PREAMBLE;
            pre_cnt <= '0;
          end
        end

        ST_PREAMBLE: begin
          tx_valid <= 1'b1;
          tx_data  <= PREAMBLE_BYTE;
          pre_cnt  <= pre_cnt + 3'd1;
          if (pre_cnt == 3'd6) state <= ST_SFD;
        end

        ST_SFD: begin
          tx_valid  <= 1'b1;
          tx_data   <= SFD_BYTE;
          eth_start <= 1'b1;
          crc       <= CRC_INIT;
          byte_cnt  <= '0;
          state     <= ST_ETH;
        end

        ST_ETH, ST_IP, ST_UDP: begin
          tx_valid <= 1'b1;
          if (!seg_valid_c) begin
            // Underrun: one filler byte flagged as errored, no FCS.
            tx_err <= 1'b1;
            state  <= ST_ABORT;
          end else begin
            tx_data  <= seg_data_c;
            crc      <= crc_next_c;
            byte_cnt <= cnt_inc_c;
            if (seg_last_c && state == ST_UDP) begin
              fcs_idx <= '0;
              state   <= (cnt_inc_c < CNT_W'(MIN_FRAME)) ? ST_PAD : ST_FCS;
            end else if (cnt_inc_c == CNT_W'(MAX_FRAME)) begin
              tx_err <= 1'b1;
              state  <= ST_ABORT;
            end else if (seg_last_c && state == ST_ETH) begin
              ip_start <= 1'b1;
              state    <= ST_IP;
            end else if (seg_last_c) begin
              udp_start <= 1'b1;
              state     <= ST_UDP;
            end
          end
        end

        ST_PAD: begin
          tx_valid <= 1'b1;
          crc      <= crc_next_c;
          byte_cnt <= cnt_inc_c;
          if (cnt_inc_c == CNT_W'(MIN_FRAME)) begin
            fcs_idx <= '0;
            state   <= ST_FCS;
          end
        end

        ST_FCS: begin
          tx_valid <= 1'b1;
          tx_data  <= fcs_c[{fcs_idx, 3'b000} +: 8];
          fcs_idx  <= fcs_idx + 2'd1;
          if (fcs_idx == 2'd3) begin
            ifg_cnt <= '0;
            state   <= ST_IFG;
          end
        end

        // The abort cycle is the first idle cycle of the gap.
        ST_ABORT: begin
          ifg_cnt <= IFG_W'(1);
          state   <= ST_IFG;
        end

        ST_IFG: begin
          frame_done <= (ifg_cnt == '0);
          ifg_cnt    <= ifg_cnt + IFG_W'(1);
          if (ifg_cnt == IFG_W'(IFG_BYTES - 1)) begin
            if (pending) begin
              pending <= 1'b0;
              pre_cnt <= '0;
              state   <= ST_PREAMBLE;
            end else begin
              state <= ST_IDLE;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_tx_sequencer.sv
// Randomised frame bench: segment sources react to start pulses, and each
// frame is compared against a byte-stream model built from the frame rules.
module tb_eth_tx_sequencer;
  import eth_tx_pkg::*;

  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       phy_ready, send;
  logic       eth_start, ip_start, udp_start;
  logic [7:0] eth_data, ip_data, udp_data;
  logic       eth_valid, ip_valid, udp_valid;
  logic       eth_last, ip_last, udp_last;
  logic [7:0] tx_data;
  logic       tx_valid, tx_err, busy, frame_done;

  int n_cmp = 0;
  int n_bad = 0;

  // Source configuration and state (segment 0 = eth, 1 = ip, 2 = udp).
  int         seg_len[3];
  logic [7:0] seg_mem[3][2048];
  int         und_seg, und_idx;
  bit         no_last;
  bit         act[3];
  int         idx[3];
  bit         drv_v[3], drv_l[3];

  always #4 clk = ~clk;

  eth_tx_sequencer dut (
    .clk(clk), .rst(rst), .phy_ready(phy_ready), .send(send),
    .eth_start(eth_start), .ip_start(ip_start), .udp_start(udp_start),
    .eth_data(eth_data), .ip_data(ip_data), .udp_data(udp_data),
    .eth_valid(eth_valid), .ip_valid(ip_valid), .udp_valid(udp_valid),
    .eth_last(eth_last), .ip_last(ip_last), .udp_last(udp_last),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_err(tx_err),
    .busy(busy), .frame_done(frame_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Software CRC-32 (reflected form), no final inversion.
  function automatic logic [31:0] sw_crc(input bq_t q, input int from);
    logic [31:0] c = 32'hFFFFFFFF;
    for (int i = from; i < q.size(); i++) begin
      c = c ^ {24'h0, q[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  // Expected tx_valid byte stream; err_at is the index of the errored byte or -1.
  function automatic void build_exp(output bq_t q, output int err_at);
    int cnt = 0;
    bit done = 0;
    logic [31:0] fcs;
    q = {};
    err_at = -1;
    repeat (7) q.push_back(8'h55);
    q.push_back(8'hD5);
    for (int s = 0; s < 3 && !done; s++) begin
      for (int k = 0; !done; k++) begin
        bit fin = (k == seg_len[s] - 1) && !(no_last && s == 2);
        if (und_seg == s && und_idx == k) begin
          q.push_back(8'h00); err_at = q.size() - 1; done = 1;
        end else begin
          q.push_back(seg_mem[s][k]);
          cnt++;
          if (fin && s == 2) done = 1;
          else if (cnt == 1514) begin err_at = q.size() - 1; done = 1; end
          else if (fin) break;
        end
      end
    end
    if (err_at < 0) begin
      while (cnt < 60) begin q.push_back(8'h00); cnt++; end
      fcs = ~sw_crc(q, 8);
      for (int b = 0; b < 4; b++) q.push_back(8'((fcs >> (8 * b)) & 32'hFF));
    end
  endfunction

  task automatic cfg(input int e, input int i, input int u);
    seg_len[0] = e; seg_len[1] = i; seg_len[2] = u;
    for (int s = 0; s < 3; s++)
      for (int k = 0; k < 2048; k++) seg_mem[s][k] = 8'($urandom);
    und_seg = -1; und_idx = -1; no_last = 0;
  endtask

  // Segment sources: react to start pulses and stream one byte per cycle.
  initial begin
    eth_valid = 0; ip_valid = 0; udp_valid = 0;
    eth_last = 0; ip_last = 0; udp_last = 0;
    eth_data = 0; ip_data = 0; udp_data = 0;
    act = '{0, 0, 0}; idx = '{0, 0, 0}; drv_v = '{0, 0, 0}; drv_l = '{0, 0, 0};
    forever begin
      @(posedge clk); #1;
      for (int s = 0; s < 3; s++)
        if (act[s]) begin
          if (drv_v[s] && !drv_l[s]) idx[s] = (idx[s] < 2047) ? idx[s] + 1 : idx[s];
          else act[s] = 0;
        end
      if (eth_start === 1'b1) begin act = '{1, 0, 0}; idx = '{0, 0, 0}; end
      if (ip_start === 1'b1)  begin act[1] = 1; idx[1] = 0; end
      if (udp_start === 1'b1) begin act[2] = 1; idx[2] = 0; end
      for (int s = 0; s < 3; s++) begin
        drv_v[s] = act[s] && !(und_seg == s && und_idx == idx[s]);
        drv_l[s] = act[s] && !(no_last && s == 2) && (idx[s] == seg_len[s] - 1);
      end
      eth_valid = drv_v[0]; eth_last = drv_l[0]; eth_data = act[0] ? seg_mem[0][idx[0]] : 8'h00;
      ip_valid  = drv_v[1]; ip_last  = drv_l[1]; ip_data  = act[1] ? seg_mem[1][idx[1]] : 8'h00;
      udp_valid = drv_v[2]; udp_last = drv_l[2]; udp_data = act[2] ? seg_mem[2][idx[2]] : 8'h00;
    end
  end

  // One-cycle send; returns at the negedge showing the first preamble byte.
  task automatic start_send(input string tag);
    @(negedge clk); send = 1;
    @(negedge clk); send = 0;
    check({tag, ".idle_after_req"}, {busy, tx_valid}, 2'b00);
    @(negedge clk);
  endtask

  // Collect one frame starting at the current negedge and check it plus the gap.
  task automatic check_frame(input string tag, input bit chain);
    bq_t exp, got;
    int err_at, got_err = -1, fd_in = 0, fd_gap = 0, idle = 0, guard = 0, nbytes = 0;
    logic fd_first;
    build_exp(exp, err_at);
    check({tag, ".pre"}, tx_valid, 1'b1);
    while (tx_valid === 1'b1 && guard < 1700) begin
      got.push_back(tx_data);
      if (tx_err === 1'b1 && got_err < 0) got_err = got.size() - 1;
      if (frame_done === 1'b1) fd_in++;
      send = chain && (got.size() == exp.size() - 2);
      @(negedge clk);
      guard++;
    end
    send = 0;
    check({tag, ".len"}, got.size(), exp.size());
    for (int i = 0; i < got.size() && i < exp.size(); i++)
      if (i != err_at && got[i] !== exp[i]) nbytes++;
    check({tag, ".bytes"}, nbytes, 0);
    check({tag, ".err_at"}, got_err, err_at);
    check({tag, ".done_in_frame"}, fd_in, 0);
    if (err_at < 0 && got.size() == exp.size()) begin
      logic [31:0] res, rev;
      res = sw_crc(got, 8);
      for (int b = 0; b < 32; b++) rev[b] = res[31-b];
      check({tag, ".residue"}, rev, CRC_RESIDUE);
    end
    fd_first = frame_done;
    check({tag, ".done_first"}, fd_first, (err_at < 0) ? 1'b1 : 1'b0);
    while (tx_valid !== 1'b1 && busy === 1'b1 && idle < 20) begin
      if (frame_done === 1'b1) fd_gap++;
      idle++;
      @(negedge clk);
    end
    check({tag, ".ifg"}, idle, 12);
    check({tag, ".done_count"}, fd_gap, (err_at < 0) ? 1 : 0);
    check({tag, ".after_gap"}, tx_valid, chain ? 1'b1 : 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    send = 0; phy_ready = 0;
    und_seg = -1; und_idx = -1; no_last = 0;
    #1 rst = 1;
    repeat (3) @(negedge clk);
    check("rst.tx_data", tx_data, 8'h00);
    check("rst.ctl", {tx_valid, tx_err, busy, frame_done, eth_start, ip_start, udp_start}, 7'h0);
    rst = 0;

    // Requests are dropped while the PHY is not ready.
    @(negedge clk); send = 1;
    @(negedge clk); send = 0;
    seen = 0;
    repeat (20) begin @(negedge clk); if (tx_valid === 1'b1 || busy === 1'b1) seen++; end
    check("no_phy", seen, 0);
    phy_ready = 1;

    // Minimum frame with a request during FCS, then the queued frame.
    cfg(14, 20, 8);
    start_send("min");
    check_frame("min", 1);
    cfg(14, 20, 30);
    check_frame("pend", 0);

    for (int f = 0; f < 4; f++) begin
      cfg(14, $urandom_range(20, 60), $urandom_range(1, 200));
      start_send($sformatf("rnd%0d", f));
      check_frame($sformatf("rnd%0d", f), 0);
    end

    cfg(14, 20, 1480);
    start_send("large");
    check_frame("large", 0);

    cfg(14, 20, 40); und_seg = 2; und_idx = 2;
    start_send("und_udp");
    check_frame("und_udp", 0);

    cfg(14, 20, 40); und_seg = 0; und_idx = $urandom_range(1, 12);
    start_send("und_eth");
    check_frame("und_eth", 0);

    cfg(14, 20, 1600); no_last = 1;
    start_send("oversize");
    check_frame("oversize", 0);

    // Reset in the middle of the Ethernet header.
    cfg(14, 20, 50);
    start_send("rst_mid");
    repeat (10) @(negedge clk);
    #1 rst = 1;
    #1;
    check("rst_mid.tx_data", tx_data, 8'h00);
    check("rst_mid.ctl", {tx_valid, tx_err, busy, frame_done, eth_start, ip_start, udp_start}, 7'h0);
    @(negedge clk); send = 1; rst = 0;
    @(negedge clk); send = 0;
    check("post_rst.idle_after_req", {busy, tx_valid}, 2'b00);
    @(negedge clk);
    check_frame("post_rst", 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
